// File: rtl/alu_op_issuer_if.sv
// -----------------------------------------------------------------------------
// alu_op_issuer_if
// Handshake bundle between decode, the ALU operation issuer and execute.
//   Request channel (decode -> issuer):
//     in_valid  request present on ALUOp/Funct3/Funct7
//     in_ready  issuer can accept the request this cycle
//     ALUOp     instruction class (00 ld/st, 01 branch, 10 R-type, 11 reserved)
//     Funct3    instruction funct3
//     Funct7    instruction funct7
//   Operation channel (issuer -> execute):
//     op_valid  Operation holds an issued code
//     op_ready  consumer accepts Operation this cycle
//     Operation registered ALU operation code
// Modports: master = decode/execute side (drives requests, accepts codes),
//           slave  = the issuer itself.
// -----------------------------------------------------------------------------
interface alu_op_issuer_if #(
  parameter int OPCODE_LENGTH = 4
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               ALUOp;
  logic [2:0]               Funct3;
  logic [6:0]               Funct7;
  logic                     op_valid;
  logic                     op_ready;
  logic [OPCODE_LENGTH-1:0] Operation;

  modport master (
    output in_valid, ALUOp, Funct3, Funct7, op_ready,
    input  in_ready, op_valid, Operation
  );

  modport slave (
    input  in_valid, ALUOp, Funct3, Funct7, op_ready,
    output in_ready, op_valid, Operation
  );
endinterface

// File: rtl/alu_op_issuer.sv
// -----------------------------------------------------------------------------
// alu_op_issuer
// Buffers decoded instruction fields in a small FIFO, decodes the head into a
// 4-bit ALU Operation code and issues it to execute over valid/ready. Heads
// with no ALU encoding are dropped and flagged with a one-cycle pulse.
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous active-high reset
//   bus          alu_op_issuer_if.slave (request + operation handshakes)
//   illegal      one-cycle pulse after an unencodable head was dropped
//   issued_count wrapping count of completed op_valid && op_ready transfers
// -----------------------------------------------------------------------------
module alu_op_issuer #(
  parameter int OPCODE_LENGTH = 4,
  parameter int FIFO_DEPTH    = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_op_issuer_if.slave       bus,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] issued_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 12;  // {ALUOp, Funct3, Funct7}
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);

  // FIFO state
  logic [EW-1:0]            r_mem [FIFO_DEPTH];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_rd_ptr;
  logic [CW-1:0]            r_count;

  // Output stage
  logic                     r_op_valid;
  logic [OPCODE_LENGTH-1:0] r_operation;
  logic                     r_illegal;
  logic [CNT_WIDTH-1:0]     r_issued_count;

  logic                     w_in_ready;
  logic                     w_push;
  logic                     w_nonempty;
  logic                     w_out_free;
  logic                     w_xfer;
  logic [EW-1:0]            w_head;
  logic [1:0]               w_head_aluop;
  logic [2:0]               w_head_f3;
  logic [6:0]               w_head_f7;
  logic                     w_head_legal;
  logic [OPCODE_LENGTH-1:0] w_head_code;
  logic                     w_pop;
  logic                     w_load;

  // Ready comes from registered occupancy only, so there is no
  // combinational path from in_valid or op_ready.
  assign w_in_ready = (r_count < DEPTH_C);
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_nonempty = (r_count != '0);
  assign w_out_free = !r_op_valid || bus.op_ready;
  assign w_xfer     = r_op_valid && bus.op_ready;

  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_aluop = w_head[11:10];
  assign w_head_f3    = w_head[9:7];
  assign w_head_f7    = w_head[6:0];

  always_comb begin
    w_head_legal = 1'b0;
    w_head_code  = OP_ADD;
    unique case (w_head_aluop)
      2'b00: begin
        w_head_legal = 1'b1;
        w_head_code  = OP_ADD;
      end
      2'b01: begin
        if (w_head_f3 == 3'b000) begin
          w_head_legal = 1'b1;
          w_head_code  = OP_EQ;
        end
      end
      2'b10: begin
        if (w_head_f3 == 3'b000 && w_head_f7 == 7'b0000000) begin
          w_head_legal = 1'b1;
          w_head_code  = OP_ADD;
        end else if (w_head_f3 == 3'b000 && w_head_f7 == 7'b0100000) begin
          w_head_legal = 1'b1;
          w_head_code  = OP_SUB;
        end else if (w_head_f3 == 3'b111 && w_head_f7 == 7'b0000000) begin
          w_head_legal = 1'b1;
          w_head_code  = OP_AND;
        end else if (w_head_f3 == 3'b110 && w_head_f7 == 7'b0000000) begin
          w_head_legal = 1'b1;
          w_head_code  = OP_OR;
        end
      end
      default: begin
        w_head_legal = 1'b0;
      end
    endcase
  end

  // Illegal heads are discarded immediately even when the output stage is
  // stalled; legal heads wait until the output stage is empty or draining.
  assign w_pop  = w_nonempty && (!w_head_legal || w_out_free);
  assign w_load = w_pop && w_head_legal;

  // Storage is not reset: occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.ALUOp, bus.Funct3, bus.Funct7};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op_valid     <= 1'b0;
      r_operation    <= '0;
      r_illegal      <= 1'b0;
      r_issued_count <= '0;
    end else begin
      r_illegal <= w_pop && !w_head_legal;
      if (w_load) begin
        r_op_valid  <= 1'b1;
        r_operation <= w_head_code;
      end else if (w_xfer) begin
        // Drained with nothing legal behind it: keep the last code visible.
        r_op_valid <= 1'b0;
      end
      if (w_xfer) begin
        r_issued_count <= r_issued_count + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.op_valid  = r_op_valid;
  assign bus.Operation = r_operation;
  assign illegal       = r_illegal;
  assign issued_count  = r_issued_count;

endmodule

// File: doc/alu_op_issuer.md
# alu_op_issuer

Registered operation issuer that turns decoded instruction fields (ALUOp, Funct3, Funct7) into the 4-bit ALU `Operation` codes and delivers them to the execute stage over a valid/ready handshake. It sits between decode and execute. It buffers up to two requests in a FIFO and holds each issued code stable until the consumer accepts it. Field combinations that have no ALU encoding are dropped and flagged.

## Interface
- `OPCODE_LENGTH`, 4, width of the `Operation` code.
- `FIFO_DEPTH`, 2, request buffer entries; must be a power of two ≥2.
- `CNT_WIDTH`, 16, width of the issued-operation counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in_valid`  in  1  request present on `ALUOp`/`Funct3`/`Funct7`.
- `in_ready`  out  1  FIFO can accept; `in_ready = (count < FIFO_DEPTH)`.
- `ALUOp`  in  2  class: 00 load/store, 01 branch, 10 R-type, 11 reserved.
- `Funct3`  in  3  instruction funct3.
- `Funct7`  in  7  instruction funct7.
- `op_valid`  out  1  `Operation` holds an issued code.
- `op_ready`  in  1  consumer accepts `Operation` this cycle.
- `Operation`  out  OPCODE_LENGTH  registered ALU code.
- `illegal`  out  1  one-cycle pulse when an unencodable request is dropped.
- `issued_count`  out  CNT_WIDTH  number of completed `op_valid && op_ready` transfers; wraps.

## Operation
- Decode of the FIFO head:
  - ALUOp 00 → 0010 (ADD).
  - ALUOp 01 with Funct3 000 → 1000 (Equal). Any other Funct3 is illegal.
  - ALUOp 10 with Funct3 000: Funct7 0000000 → 0010 (ADD), Funct7 0100000 → 0110 (SUB).
  - ALUOp 10 with Funct3 111 and Funct7 0000000 → 0000 (AND).
  - ALUOp 10 with Funct3 110 and Funct7 0000000 → 0001 (OR).
  - All other ALUOp 10 combinations, and all ALUOp 11, are illegal.
- Push: when `in_valid && in_ready`, the raw fields are written at the tail.
- Output stage is empty or draining when `!op_valid || op_ready`.
- Pop, legal head: if the FIFO is non-empty and the output stage is empty or draining, the head is popped. The decoded code loads into `Operation` and `op_valid` = 1.
- Pop, illegal head: the head is popped whenever the FIFO is non-empty, regardless of output stage state. `illegal` pulses, and `op_valid`/`Operation` follow the drain rule: `op_valid` clears if it was draining, otherwise both hold.
- Pop limit: at most one pop per cycle.
- Hold rule: while `op_valid && !op_ready`, `Operation` and `op_valid` must not change.
- Drain with nothing behind it: on `op_valid && op_ready` with no legal head loading, `op_valid` goes to 0 and `Operation` keeps its last value.
- Counter: `issued_count` increments on every `op_valid && op_ready` and wraps from 2^CNT_WIDTH−1 to 0.
- Simultaneous push and pop are allowed in one cycle; count is unchanged. When full, `in_ready` = 0, so there is no push even if a pop occurs that cycle (no bypass).
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Occupancy is tracked by a separate count of 0..FIFO_DEPTH.

## Timing
- Reset values (asynchronous, while `reset` = 1):
  - FIFO empty, count 0.
  - `in_ready` = 1, `op_valid` = 0, `Operation` = 0000, `illegal` = 0, `issued_count` = 0.
- Reset mid-operation discards buffered and issued requests; nothing is counted.
- Latency: a request accepted at edge k appears with `op_valid` = 1 after edge k+1 (two-register path, no combinational input→output path).
- Throughput: with `op_ready` held high, one code issues per cycle.
- `illegal` is high for exactly the cycle after the edge that popped the illegal entry.
- `in_ready` depends only on registered count, never on `in_valid` or `op_ready`.

## Test plan
- Reset then single request: ALUOp=10, F3=000, F7=0100000, accepted at edge 1, `op_ready`=1 → `op_valid`=1 and `Operation`=0110 after edge 2. Then `issued_count`=1 and `op_valid`=0.
- Backpressure: push ADD, AND, OR with `op_ready`=0.
  - `Operation`=0010 holds.
  - `in_ready` drops to 0 after the 3rd accept (two in FIFO, one in output).
  - Release `op_ready` → codes 0010, 0000, 0001 issue in order on consecutive cycles; `issued_count`=3.
- Illegal handling: push ALUOp=11, then ALUOp=01/F3=000 → `illegal` pulses once, no issue for the first. `Operation`=1000 issues next cycle, and `issued_count` counts only 1.
- Simultaneous push/pop at occupancy 1 with `op_ready`=1 over 8 cycles of ALUOp=00 → continuous `op_valid`, all 0010, count stable, `issued_count`=8.
- Reset asserted mid-stream (FIFO full, `op_valid`=1) → all outputs return to reset values immediately, without waiting for a clock edge. After release, a new request issues with 2-cycle latency.
- Counter wrap with `CNT_WIDTH`=4: 17 transfers → `issued_count`=1.
